// File: rtl/enum_stim_sequencer.sv
// Walks an int, a bit[2:0] and a logic[1:0] stimulus channel through every member in order,
// each value held HOLD clocks after a LEAD-clock lead-in; optional x/z tail via ENUM_STIM_SEQUENCER_XZ_EN.
module enum_stim_sequencer #(
    parameter int LEAD    = 4,
    parameter int HOLD    = 1,
    parameter int N_INT   = 7,
    parameter int N_BIT   = 5,
    parameter int N_LOGIC = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  phase_o,
    output logic [31:0] int_val_o,
    output logic        int_vld_o,
    output logic [2:0]  bit_val_o,
    output logic        bit_vld_o,
    output logic [1:0]  log_val_o,
    output logic        log_vld_o
);

`ifdef ENUM_STIM_SEQUENCER_XZ_EN
    // Two extra logic-channel steps carry the x and z values.
    localparam int N_LOG_STEPS = N_LOGIC + 2;
`else
    localparam int N_LOG_STEPS = N_LOGIC;
`endif

    localparam int MAXN_IB = (N_INT > N_BIT) ? N_INT : N_BIT;
    localparam int MAXN    = (MAXN_IB > N_LOG_STEPS) ? MAXN_IB : N_LOG_STEPS;
    localparam int IW      = (MAXN > 1) ? $clog2(MAXN) : 1;
    localparam int LW      = $clog2(LEAD + 1);
    localparam int HW      = $clog2(HOLD + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_RUN_INT,
        S_RUN_BIT,
        S_RUN_LOG,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [LW-1:0]  lead_q, lead_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [31:0]    int_val_q, int_val_d;
    logic [2:0]     bit_val_q, bit_val_d;
    logic [1:0]     log_val_q, log_val_d;

    logic [IW-1:0]  last_idx;
    state_t         after_state;
    logic           in_run;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            lead_q    <= '0;
            hold_q    <= '0;
            idx_q     <= '0;
            int_val_q <= '0;
            bit_val_q <= '0;
            log_val_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            lead_q    <= lead_d;
            hold_q    <= hold_d;
            idx_q     <= idx_d;
            int_val_q <= int_val_d;
            bit_val_q <= bit_val_d;
            log_val_q <= log_val_d;
        end
    end

    // Per-channel end index and successor, shared by the common run-step logic below.
    always_comb begin
        last_idx    = '0;
        after_state = S_IDLE;
        in_run      = 1'b0;
        case (state_q)
            S_RUN_INT: begin
                last_idx    = IW'(N_INT - 1);
                after_state = S_RUN_BIT;
                in_run      = 1'b1;
            end
            S_RUN_BIT: begin
                last_idx    = IW'(N_BIT - 1);
                after_state = S_RUN_LOG;
                in_run      = 1'b1;
            end
            S_RUN_LOG: begin
                last_idx    = IW'(N_LOG_STEPS - 1);
                after_state = S_DONE;
                in_run      = 1'b1;
            end
            default: begin
                last_idx    = '0;
                after_state = S_IDLE;
                in_run      = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        lead_d    = lead_q;
        hold_d    = hold_q;
        idx_d     = idx_q;
        int_val_d = int_val_q;
        bit_val_d = bit_val_q;
        log_val_d = log_val_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d = S_LEAD;
                    lead_d  = LW'(LEAD - 1);
                end
            end
            S_LEAD: begin
                if (lead_q == '0) begin
                    state_d = S_RUN_INT;
                    idx_d   = '0;
                    hold_d  = HW'(HOLD - 1);
                end else begin
                    lead_d = lead_q - LW'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: begin
                if (in_run) begin
                    if (hold_q != '0) begin
                        hold_d = hold_q - HW'(1);
                    end else begin
                        hold_d = HW'(HOLD - 1);
                        if (idx_q == last_idx) begin
                            idx_d   = '0;
                            state_d = after_state;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
            end
        endcase

        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end

        // Channel values only move while their channel is the active one, so they hold afterwards.
        case (state_d)
            S_RUN_INT: int_val_d = 32'(idx_d);
            S_RUN_BIT: bit_val_d = 3'(idx_d);
            S_RUN_LOG: begin
`ifdef ENUM_STIM_SEQUENCER_XZ_EN
                if (idx_d == IW'(N_LOGIC)) begin
                    log_val_d = 2'bxx;
                end else if (idx_d == IW'(N_LOGIC + 1)) begin
                    log_val_d = 2'bzz;
                end else begin
                    log_val_d = 2'(idx_d);
                end
`else
                log_val_d = 2'(idx_d);
`endif
            end
            default: log_val_d = log_val_q;
        endcase
    end

    always_comb begin
        busy_o    = (state_q != S_IDLE);
        done_o    = (state_q == S_DONE);
        int_vld_o = (state_q == S_RUN_INT);
        bit_vld_o = (state_q == S_RUN_BIT);
        log_vld_o = (state_q == S_RUN_LOG);
        phase_o   = 2'd0;
        case (state_q)
            S_RUN_INT: phase_o = 2'd1;
            S_RUN_BIT: phase_o = 2'd2;
            S_RUN_LOG: phase_o = 2'd3;
            default:   phase_o = 2'd0;
        endcase
        int_val_o = int_val_q;
        bit_val_o = bit_val_q;
        log_val_o = log_val_q;
    end

endmodule

// File: tb/tb_enum_stim_sequencer.sv
// Bench for enum_stim_sequencer: a default-HOLD and a HOLD=3 instance share stimulus and are
// compared every cycle against a position-in-run reference model.
module tb_enum_stim_sequencer;

    localparam int LEAD = 4;
    localparam int NI   = 7;
    localparam int NB   = 5;
    localparam int NL   = 4;
`ifdef ENUM_STIM_SEQUENCER_XZ_EN
    localparam int XZ = 1;
`else
    localparam int XZ = 0;
`endif
    localparam int NLS = NL + 2 * XZ;

    logic clk = 1'b0;
    logic rst, start, abort;

    logic        busy0, done0, ivld0, bvld0, lvld0;
    logic [1:0]  phase0, lval0;
    logic [31:0] ival0;
    logic [2:0]  bval0;
    logic        busy1, done1, ivld1, bvld1, lvld1;
    logic [1:0]  phase1, lval1;
    logic [31:0] ival1;
    logic [2:0]  bval1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit act;
        int u;
        int iv;
        int bv;
        int lv;
        bit lvx;
    } mdl_t;

    mdl_t m0, m1;

    always #5 clk = ~clk;

    enum_stim_sequencer dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .busy_o(busy0), .done_o(done0), .phase_o(phase0),
        .int_val_o(ival0), .int_vld_o(ivld0), .bit_val_o(bval0), .bit_vld_o(bvld0),
        .log_val_o(lval0), .log_vld_o(lvld0)
    );

    enum_stim_sequencer #(.HOLD(3)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .busy_o(busy1), .done_o(done1), .phase_o(phase1),
        .int_val_o(ival1), .int_vld_o(ivld1), .bit_val_o(bval1), .bit_vld_o(bvld1),
        .log_val_o(lval1), .log_vld_o(lvld1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // u counts clocks since the accepting edge (1 = first lead clock).
    // ch: 0 lead, 1 int, 2 bit, 3 logic, 4 done cycle.
    function automatic void where(input int u, input int h, output int ch, output int idx);
        int k;
        k   = u - LEAD - 1;
        idx = 0;
        if (k < 0) begin
            ch = 0;
        end else if (k < h * NI) begin
            ch = 1; idx = k / h;
        end else if (k < h * (NI + NB)) begin
            ch = 2; idx = (k - h * NI) / h;
        end else if (k < h * (NI + NB + NLS)) begin
            ch = 3; idx = (k - h * (NI + NB)) / h;
        end else begin
            ch = 4;
        end
    endfunction

    function automatic mdl_t advance(input mdl_t m, input int h, input bit r, input bit s, input bit a);
        mdl_t n;
        int ch, idx;
        n = m;
        if (r) begin
            n = '{act: 1'b0, u: 0, iv: 0, bv: 0, lv: 0, lvx: 1'b0};
        end else if (!m.act) begin
            if (s && !a) begin
                n.act = 1'b1;
                n.u   = 1;
            end
        end else if (a) begin
            n.act = 1'b0;
        end else begin
            where(m.u, h, ch, idx);
            if (ch == 4) n.act = 1'b0;
            else n.u = m.u + 1;
        end
        if (n.act) begin
            where(n.u, h, ch, idx);
            if (ch == 1) n.iv = idx;
            if (ch == 2) n.bv = idx;
            if (ch == 3) begin
                if (idx >= NL) n.lvx = 1'b1;
                else begin
                    n.lv  = idx;
                    n.lvx = 1'b0;
                end
            end
        end
        return n;
    endfunction

    task automatic check_dut(input string p, input mdl_t m, input int h,
                             input logic busy, input logic done, input logic [1:0] phase,
                             input logic [31:0] iv, input logic ivld, input logic [2:0] bv,
                             input logic bvld, input logic [1:0] lv, input logic lvld);
        int ch, idx;
        ch = -1;
        idx = 0;
        if (m.act) where(m.u, h, ch, idx);
        check({p, "_busy"}, 32'(busy), 32'(m.act));
        check({p, "_done"}, 32'(done), 32'(ch == 4));
        check({p, "_phase"}, 32'(phase), (ch >= 1 && ch <= 3) ? 32'(ch) : 32'd0);
        check({p, "_int_vld"}, 32'(ivld), 32'(ch == 1));
        check({p, "_bit_vld"}, 32'(bvld), 32'(ch == 2));
        check({p, "_log_vld"}, 32'(lvld), 32'(ch == 3));
        check({p, "_int_val"}, iv, 32'(m.iv));
        check({p, "_bit_val"}, 32'(bv), 32'(m.bv));
        if (!m.lvx) check({p, "_log_val"}, 32'(lv), 32'(m.lv));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        m0 = advance(m0, 1, rst, start, abort);
        m1 = advance(m1, 3, rst, start, abort);
        check_dut("h1", m0, 1, busy0, done0, phase0, ival0, ivld0, bval0, bvld0, lval0, lvld0);
        check_dut("h3", m1, 3, busy1, done1, phase1, ival1, ivld1, bval1, bvld1, lval1, lvld1);
    endtask

    initial begin
        int s0, d0, d1;
        int dn;
        dn = 21 + 2 * XZ;
        m0 = '{act: 1'b0, u: 0, iv: 0, bv: 0, lv: 0, lvx: 1'b0};
        m1 = m0;

        // Reset held with start high.
        rst = 1'b1; start = 1'b1; abort = 1'b0;
        repeat (3) tick();
        check("t1_busy", 32'(busy0), 32'd0);
        check("t1_ival", ival0, 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();

        // Full run on both instances; done cycle measured from the start cycle.
        s0 = cyc; d0 = -1; d1 = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (done0 && d0 < 0) d0 = cyc - s0;
            if (done1 && d1 < 0) d1 = cyc - s0;
            if (cyc - s0 == 5)  check("t2_ival_c5", ival0, 32'd0);
            if (cyc - s0 == 17) check("t2_lval_c17", 32'(lval0), 32'd0);
            if (cyc - s0 == 9)  check("t3_ival_c9", ival1, 32'd1);
            tick();
        end
        check("t2_done_cycle", 32'(d0), 32'(dn));
        check("t3_done_cycle", 32'(d1), 32'(53 + 6 * XZ));

        // Abort during bit_val=1, then restart.
        s0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < s0 + 13) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_bit_hold", 32'(bval0), 32'd1);
        check("t4_bit_vld", 32'(bvld0), 32'd0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < s0 + 20) tick();
        check("t4_restart_vld", 32'(ivld0), 32'd1);
        check("t4_restart_val", ival0, 32'd0);
        repeat (70) tick();

        // Start while busy is ignored; start right after done is accepted.
        s0 = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < s0 + 3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < s0 + dn) tick();
        check("t5_done", 32'(done0), 32'd1);
        start = 1'b1;
        tick();
        check("t5_idle", 32'(busy0), 32'd0);
        tick();
        start = 1'b0;
        check("t5_restart", 32'(busy0), 32'd1);
        repeat (70) tick();

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 5) == 0);
            abort = ($urandom_range(0, 79) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
